// File: rtl/conv_operand_sequencer_if.sv
// Load/stream bus of the convolution operand sequencer.
// master = producer/consumer side, slave = sequencer.
interface conv_operand_sequencer_if #(
    parameter int unsigned DW = 16
);
    logic          load_valid;
    logic          load_ready;
    logic [DW-1:0] load_pixel;
    logic [DW-1:0] load_weight;
    logic          start;
    logic          busy;
    logic [DW-1:0] pixel_out;
    logic [DW-1:0] weight_out;
    logic          sel_out;
    logic          out_valid;
    logic [3:0]    tap_idx;
    logic          done;

    modport master (
        output load_valid, load_pixel, load_weight, start,
        input  load_ready, busy, pixel_out, weight_out, sel_out, out_valid, tap_idx, done
    );

    modport slave (
        input  load_valid, load_pixel, load_weight, start,
        output load_ready, busy, pixel_out, weight_out, sel_out, out_valid, tap_idx, done
    );
endinterface

// File: rtl/conv_operand_sequencer.sv
// Buffers one window of TAPS pixel/weight pairs and presents each tap to the
// FP16 operand mux for two cycles: pixel phase (sel 0) then weight phase (sel 1).
module conv_operand_sequencer #(
    parameter int unsigned TAPS = 9,
    parameter int unsigned DW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    conv_operand_sequencer_if.slave  bus
);
    localparam int unsigned CW = $clog2(TAPS + 1);
    localparam int unsigned AW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned TW = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [DW-1:0] pix_mem [TAPS];
    logic [DW-1:0] wgt_mem [TAPS];

    logic          accept_c;
    logic [TW-1:0] next_tap_c;
    logic          last_tap_c;

    assign accept_c   = (state == LOAD) && bus.load_valid && bus.load_ready;
    assign next_tap_c = bus.tap_idx + TW'(1);
    assign last_tap_c = (bus.tap_idx == TW'(TAPS - 1));

    // Window storage; contents are only meaningful once the slot has been loaded.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            pix_mem[AW'(count)] <= bus.load_pixel;
            wgt_mem[AW'(count)] <= bus.load_weight;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LOAD;
            count          <= '0;
            bus.load_ready <= 1'b1;
            bus.busy       <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.sel_out    <= 1'b0;
            bus.done       <= 1'b0;
            bus.pixel_out  <= '0;
            bus.weight_out <= '0;
            bus.tap_idx    <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (accept_c) begin
                        count <= count + CW'(1);
                        if (count == CW'(TAPS - 1)) begin
                            state          <= FULL;
                            bus.load_ready <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    // start wins over a concurrent load; load_ready is already low here
                    if (bus.start) begin
                        state          <= STREAM;
                        bus.busy       <= 1'b1;
                        bus.out_valid  <= 1'b1;
                        bus.sel_out    <= 1'b0;
                        bus.tap_idx    <= '0;
                        bus.pixel_out  <= pix_mem[AW'(0)];
                        bus.weight_out <= wgt_mem[AW'(0)];
                    end
                end
                STREAM: begin
                    if (!bus.sel_out) begin
                        bus.sel_out <= 1'b1;
                    end else if (last_tap_c) begin
                        // operands and tap index hold their last values while invalid
                        state          <= LOAD;
                        count          <= '0;
                        bus.load_ready <= 1'b1;
                        bus.busy       <= 1'b0;
                        bus.out_valid  <= 1'b0;
                        bus.sel_out    <= 1'b0;
                        bus.done       <= 1'b1;
                    end else begin
                        bus.sel_out    <= 1'b0;
                        bus.tap_idx    <= next_tap_c;
                        bus.pixel_out  <= pix_mem[AW'(next_tap_c)];
                        bus.weight_out <= wgt_mem[AW'(next_tap_c)];
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_operand_sequencer.sv
// Directed bench for conv_operand_sequencer: load, stream, backpressure,
// mid-stream reset, back-to-back windows and FP16 special values.
module tb_conv_operand_sequencer;
    localparam int unsigned TAPS = 9;
    localparam int unsigned DW   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_operand_sequencer_if #(.DW(DW)) bus ();

    conv_operand_sequencer #(.TAPS(TAPS), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests    = 0;
    int failed   = 0;
    int done_cnt = 0;
    int mcnt     = 0;
    logic [DW-1:0] mp [TAPS];
    logic [DW-1:0] mw [TAPS];

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair for a single cycle; the model records it if the buffer has room.
    task automatic load_pair(input logic [DW-1:0] p, input logic [DW-1:0] w);
        bus.load_valid  = 1'b1;
        bus.load_pixel  = p;
        bus.load_weight = w;
        check("load_ready", 32'(bus.load_ready), 32'(mcnt < int'(TAPS)));
        step();
        if (mcnt < int'(TAPS)) begin
            mp[mcnt] = p;
            mw[mcnt] = w;
            mcnt++;
        end
        bus.load_valid = 1'b0;
    endtask

    // Pulse start from FULL and check every phase plus the done cycle.
    task automatic run_stream(input int busy_start_at);
        bus.start = 1'b1;
        step();
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        for (int k = 0; k < int'(TAPS); k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                check("out_valid", 32'(bus.out_valid), 32'd1);
                check("sel_out", 32'(bus.sel_out), 32'(ph));
                check("tap_idx", 32'(bus.tap_idx), 32'(k));
                check("pixel_out", 32'(bus.pixel_out), 32'(mp[k]));
                check("weight_out", 32'(bus.weight_out), 32'(mw[k]));
                check("busy", 32'(bus.busy), 32'd1);
                check("done_mid", 32'(bus.done), 32'd0);
                check("ready_busy", 32'(bus.load_ready), 32'd0);
                bus.start = ((2 * k + ph) == busy_start_at);
                step();
            end
        end
        bus.start = 1'b0;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_valid", 32'(bus.out_valid), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_sel", 32'(bus.sel_out), 32'd0);
        check("done_ready", 32'(bus.load_ready), 32'd1);
        check("hold_pixel", 32'(bus.pixel_out), 32'(mp[TAPS-1]));
        check("hold_weight", 32'(bus.weight_out), 32'(mw[TAPS-1]));
        check("hold_tap", 32'(bus.tap_idx), 32'(TAPS - 1));
        mcnt = 0;
    endtask

    initial begin
        logic [15:0] pat;
        logic [DW-1:0] spec_p [TAPS];
        logic [DW-1:0] spec_w [TAPS];
        int  snap;
        bit  early_done;
        bit  acc;

        rst             = 1'b1;
        bus.load_valid  = 1'b0;
        bus.load_pixel  = '0;
        bus.load_weight = '0;
        bus.start       = 1'b0;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pixel", 32'(bus.pixel_out), 32'd0);
        rst = 1'b0;
        step();
        check("idle_ready", 32'(bus.load_ready), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        check("idle_sel", 32'(bus.sel_out), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_pixel", 32'(bus.pixel_out), 32'd0);
        check("idle_weight", 32'(bus.weight_out), 32'd0);
        check("idle_tap", 32'(bus.tap_idx), 32'd0);

        // Window 1: back-to-back load, then a 10th pair held in FULL together with start
        for (int i = 0; i < int'(TAPS); i++) load_pair(16'h3C00 + 16'(i), 16'h4000 + 16'(i));
        check("full_ready", 32'(bus.load_ready), 32'd0);
        check("tap4_pixel_model", 32'(mp[4]), 32'h3C04);
        bus.load_valid  = 1'b1;
        bus.load_pixel  = 16'hDEAD;
        bus.load_weight = 16'hBEEF;
        step();
        check("full_ready_hold", 32'(bus.load_ready), 32'd0);
        check("full_no_stream", 32'(bus.out_valid), 32'd0);
        step();
        check("full_ready_hold2", 32'(bus.load_ready), 32'd0);
        run_stream(-1);

        // Window 2: first pair in the done cycle, then toggling valid and an early start
        load_pair(16'h5000, 16'h6000);
        check("after_done", 32'(bus.done), 32'd0);
        pat        = 16'b1011_0010_1110_0101;
        early_done = 1'b0;
        for (int i = 0; i < 64 && mcnt < int'(TAPS); i++) begin
            bus.load_valid  = pat[i % 16];
            bus.load_pixel  = 16'h5000 + 16'(mcnt);
            bus.load_weight = 16'h6000 + 16'(mcnt);
            bus.start       = (mcnt == 5) && !early_done;
            check("bp_ready", 32'(bus.load_ready), 32'd1);
            acc = bus.load_valid;
            step();
            if (bus.start) begin
                early_done = 1'b1;
                check("early_start_valid", 32'(bus.out_valid), 32'd0);
                check("early_start_busy", 32'(bus.busy), 32'd0);
            end
            bus.start = 1'b0;
            if (acc) begin
                mp[mcnt] = 16'h5000 + 16'(mcnt);
                mw[mcnt] = 16'h6000 + 16'(mcnt);
                mcnt++;
            end
        end
        bus.load_valid = 1'b0;
        check("bp_count", 32'(mcnt), 32'(TAPS));
        check("bp_full", 32'(bus.load_ready), 32'd0);
        run_stream(5);

        // Window 3: FP16 special values pass through bit-exact
        spec_p = '{16'h7C00, 16'h7E00, 16'h0001, 16'h8000, 16'hFC00, 16'h7BFF, 16'h0400, 16'h03FF, 16'hFE00};
        spec_w = '{16'h8000, 16'h0001, 16'h7E00, 16'h7C00, 16'h7FFF, 16'h8001, 16'hFBFF, 16'h0000, 16'hFFFF};
        for (int i = 0; i < int'(TAPS); i++) load_pair(spec_p[i], spec_w[i]);
        run_stream(-1);

        // Window 4: reset at tap 3, weight phase
        for (int i = 0; i < int'(TAPS); i++) load_pair(16'h1200 + 16'(i), 16'h2200 + 16'(i));
        snap      = done_cnt;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int j = 0; j < 7; j++) step();
        check("abort_tap", 32'(bus.tap_idx), 32'd3);
        check("abort_sel", 32'(bus.sel_out), 32'd1);
        check("abort_pixel", 32'(bus.pixel_out), 32'h1203);
        rst = 1'b1;
        step();
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        mcnt = 0;
        step();
        check("abort_ready", 32'(bus.load_ready), 32'd1);
        step();
        check("abort_no_done", 32'(done_cnt), 32'(snap));

        // Window 5: load restarts from slot 0 after the abort
        for (int i = 0; i < int'(TAPS); i++) load_pair(16'hA000 + 16'(i), 16'hB000 + 16'(i));
        check("w5_full", 32'(bus.load_ready), 32'd0);
        run_stream(-1);
        step();
        check("done_total", 32'(done_cnt), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
